// File: rtl/ws_tile_controller.sv
// Weight-stationary tile sequencer: loads ARRAY_ROWS weight rows, then streams
// N iact vectors per column with column skew and collects skewed psum rows.
module ws_lane #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int CW     = 20,
    parameter int OFF    = 0,
    parameter int IDX    = 0
) (
    input  logic              active,
    input  logic [CW-1:0]     c,
    input  logic [LEN_W-1:0]  n,
    input  logic [ADDR_W-1:0] base,
    output logic              strobe,
    output logic [ADDR_W-1:0] addr
);
    logic [CW-1:0] rel;

    // rel is only meaningful once c has reached this lane's skew offset
    assign rel    = c - CW'(OFF);
    assign strobe = active && (c >= CW'(OFF)) && (rel < CW'(n));
    assign addr   = strobe ? base + ADDR_W'(IDX) * ADDR_W'(n) + ADDR_W'(rel) : '0;
endmodule

module ws_tile_controller #(
    parameter int ARRAY_ROWS = 3,
    parameter int ARRAY_COLS = 3,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  stall,
    input  logic [LEN_W-1:0]                      cfg_iact_len,
    input  logic [ADDR_W-1:0]                     cfg_weight_base,
    input  logic [ADDR_W-1:0]                     cfg_iact_base,
    input  logic [ADDR_W-1:0]                     cfg_psum_base,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err,
    output logic                                  load_weight,
    output logic [ADDR_W-1:0]                     weight_addr,
    output logic [ARRAY_COLS-1:0]                 load_iact,
    output logic [ARRAY_COLS-1:0][ADDR_W-1:0]     iact_addr,
    output logic [ARRAY_ROWS-1:0]                 psum_valid,
    output logic [ARRAY_ROWS-1:0][ADDR_W-1:0]     psum_addr
);
    localparam int CW = LEN_W + $clog2(ARRAY_ROWS + ARRAY_COLS) + 1;
    localparam int KW = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k;
    logic [CW-1:0]     c;
    logic [CW-1:0]     c_last;
    logic [LEN_W-1:0]  n;
    logic [ADDR_W-1:0] wbase, ibase, pbase;
    logic              err_q;
    logic              can_start, accept, reject;

    assign can_start = (state == IDLE) || (state == DONE);
    assign accept    = start && can_start && (cfg_iact_len != '0);
    assign reject    = start && can_start && (cfg_iact_len == '0);
    assign c_last    = CW'(n) + CW'(ARRAY_ROWS + ARRAY_COLS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            c     <= '0;
            n     <= '0;
            wbase <= '0;
            ibase <= '0;
            pbase <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= reject;
            if (accept) begin
                n     <= cfg_iact_len;
                wbase <= cfg_weight_base;
                ibase <= cfg_iact_base;
                pbase <= cfg_psum_base;
                k     <= '0;
            end
            if (state == LOAD) begin
                k <= k + 1'b1;
                c <= '0;
            end
            if (state == COMPUTE && !stall)
                c <= c + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD: begin
                if (abort)                          state_nxt = IDLE;
                else if (k == KW'(ARRAY_ROWS - 1))  state_nxt = COMPUTE;
            end
            COMPUTE: begin
                if (abort)                          state_nxt = IDLE;
                else if (!stall && c == c_last)     state_nxt = DONE;
            end
            DONE:    state_nxt = accept ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state == LOAD) || (state == COMPUTE);
    assign done        = (state == DONE);
    assign err         = err_q;
    assign load_weight = (state == LOAD);
    assign weight_addr = load_weight ? wbase + ADDR_W'(k) : '0;

    logic active;
    assign active = (state == COMPUTE) && !stall;

    // iact column j enters at c=j; psum row i leaves ARRAY_COLS+1 cycles after
    // its first input, plus one cycle of skew per row
    for (genvar j = 0; j < ARRAY_COLS; j++) begin : g_iact
        ws_lane #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CW(CW), .OFF(j), .IDX(j)) u_lane (
            .active (active),
            .c      (c),
            .n      (n),
            .base   (ibase),
            .strobe (load_iact[j]),
            .addr   (iact_addr[j])
        );
    end

    for (genvar i = 0; i < ARRAY_ROWS; i++) begin : g_psum
        ws_lane #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CW(CW), .OFF(ARRAY_COLS + 1 + i), .IDX(i)) u_lane (
            .active (active),
            .c      (c),
            .n      (n),
            .base   (pbase),
            .strobe (psum_valid[i]),
            .addr   (psum_addr[i])
        );
    end
endmodule
